// File: rtl/two_of_five_tx.sv
// Serial transmitter for 2-of-5 (7-4-2-1-0) code words: one BCD digit per handshake,
// five data bits framed on SOUT/FRAME, followed by a programmable idle gap.
module two_of_five_tx #(
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] DIGIT,
  input  logic       VALID,
  output logic       READY,
  output logic       SOUT,
  output logic       FRAME,
  output logic       DONE,
  output logic       ERR,
  output logic [4:0] CODE
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int         GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [3:0] GAP_LOAD = GAP_M1[3:0];

  state_t     state_q, state_d;
  logic [4:0] shreg_q, shreg_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] code_q, code_d;
  logic       sout_q, sout_d;
  logic       frame_q, frame_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [4:0] word;

  function automatic logic [4:0] encode(input logic [3:0] d);
    logic [4:0] w;
    case (d)
      4'd0:    w = 5'b11000;
      4'd1:    w = 5'b00011;
      4'd2:    w = 5'b00101;
      4'd3:    w = 5'b00110;
      4'd4:    w = 5'b01001;
      4'd5:    w = 5'b01010;
      4'd6:    w = 5'b01100;
      4'd7:    w = 5'b10001;
      4'd8:    w = 5'b10010;
      4'd9:    w = 5'b10100;
      default: w = 5'b00000;
    endcase
    return w;
  endfunction

  assign word = encode(DIGIT);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    sout_d  = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (VALID) begin
          if (DIGIT <= 4'd9) begin
            code_d  = word;
            idx_d   = 3'd0;
            frame_d = 1'b1;
            state_d = S_SHIFT;
            // The first bit leaves the register on the acceptance edge itself.
            if (MSB_FIRST) begin
              sout_d  = word[4];
              shreg_d = {word[3:0], 1'b0};
            end else begin
              sout_d  = word[0];
              shreg_d = {1'b0, word[4:1]};
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (idx_q != 3'd4) begin
          idx_d   = idx_q + 3'd1;
          frame_d = 1'b1;
          done_d  = (idx_q == 3'd3);
          if (MSB_FIRST) begin
            sout_d  = shreg_q[4];
            shreg_d = {shreg_q[3:0], 1'b0};
          end else begin
            sout_d  = shreg_q[0];
            shreg_d = {1'b0, shreg_q[4:1]};
          end
        end else begin
          idx_d = 3'd0;
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      shreg_q <= 5'b0;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      code_q  <= 5'b0;
      sout_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sout_q  <= sout_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign READY = (state_q == S_IDLE) && !RST;
  assign SOUT  = sout_q;
  assign FRAME = frame_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign CODE  = code_q;

endmodule

// File: tb/tb_two_of_five_tx.sv
// Bench for two_of_five_tx: instance a (GAP=1, MSB first), instance b (GAP=0, LSB first),
// checked against a weight-sum model of the 7-4-2-1-0 code.
module tb_two_of_five_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a_digit = 4'd0, b_digit = 4'd0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, a_sout, a_frame, a_done, a_err;
  logic       b_ready, b_sout, b_frame, b_done, b_err;
  logic [4:0] a_code, b_code;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  two_of_five_tx #(.GAP(1), .MSB_FIRST(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .DIGIT(a_digit), .VALID(a_valid), .READY(a_ready),
    .SOUT(a_sout), .FRAME(a_frame), .DONE(a_done), .ERR(a_err), .CODE(a_code)
  );
  two_of_five_tx #(.GAP(0), .MSB_FIRST(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .DIGIT(b_digit), .VALID(b_valid), .READY(b_ready),
    .SOUT(b_sout), .FRAME(b_frame), .DONE(b_done), .ERR(b_err), .CODE(b_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: the two weights out of {7,4,2,1,0} that sum to the digit (0 is coded as 7+4).
  function automatic logic [4:0] ref_code(input int d);
    int w[5] = '{0, 1, 2, 4, 7};
    int target;
    logic [4:0] c;
    c = 5'b0;
    target = (d == 0) ? 11 : d;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (w[i] + w[j] == target) begin
          c[i] = 1'b1;
          c[j] = 1'b1;
        end
    return c;
  endfunction

  function automatic logic ref_bit(input logic [4:0] c, input int k, input bit msb);
    logic [4:0] t;
    t = c;
    return msb ? t[4-k] : t[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({a_ready, a_sout, a_frame, a_done, a_err, a_code} !== 10'b0)
      $display("FAIL reset_outputs: got %b want %b", {a_ready, a_sout, a_frame, a_done, a_err, a_code}, 10'b0);
    rst = 1'b0;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after: got %b%b want 11", a_ready, b_ready);
    end
  endtask

  task automatic test_single();
    logic [4:0] c;
    c = ref_code(7);
    a_digit = 4'd7;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    total++;
    if (a_code !== 5'b10001) begin
      bad++;
      $display("FAIL single_code: got %b want %b", a_code, 5'b10001);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({a_sout, a_frame, a_done, a_ready} !== {ref_bit(c, k, 1'b1), 1'b1, (k == 4), 1'b0}) begin
        bad++;
        $display("FAIL single_bit%0d: got %b want %b", k, {a_sout, a_frame, a_done, a_ready},
                 {ref_bit(c, k, 1'b1), 1'b1, (k == 4), 1'b0});
      end
      step();
    end
    total++;
    if ({a_sout, a_frame, a_done, a_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL single_gap: got %b want 0000", {a_sout, a_frame, a_done, a_ready});
    end
    step();
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready_cycle7: got %b want 1", a_ready);
    end
  endtask

  task automatic test_back_to_back();
    int d, n, acc, prev;
    logic [4:0] c, seen;
    prev = 0;
    for (int i = 0; i < 14; i++) begin
      d = (i < 10) ? i : int'($urandom_range(0, 9));
      c = ref_code(d);
      a_digit = 4'(d);
      a_valid = 1'b1;
      n = 0;
      while (a_ready !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      total++;
      if (n >= 20) begin
        bad++;
        $display("FAIL b2b_ready_timeout: got %0d cycles want <20", n);
      end
      step();
      acc = cyc;
      if (i > 0) begin
        total++;
        if (acc - prev != 7) begin
          bad++;
          $display("FAIL b2b_period d=%0d: got %0d want 7", d, acc - prev);
        end
      end
      prev = acc;
      seen = 5'b0;
      for (int k = 0; k < 5; k++) begin
        seen[4-k] = a_sout;
        total++;
        if ({a_frame, a_done, a_code} !== {1'b1, (k == 4), c}) begin
          bad++;
          $display("FAIL b2b_frame d=%0d k=%0d: got %b want %b", d, k, {a_frame, a_done, a_code}, {1'b1, (k == 4), c});
        end
        if (k < 4) step();
      end
      total++;
      if (seen !== c || $countones(seen) != 2) begin
        bad++;
        $display("FAIL b2b_word d=%0d: got %b want %b", d, seen, c);
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_illegal();
    int n;
    logic [4:0] prev_code;
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    prev_code = a_code;
    for (int r = 0; r < 3; r++) begin
      a_digit = 4'($urandom_range(10, 15));
      a_valid = 1'b1;
      step();
      total++;
      if ({a_err, a_frame, a_ready, a_code} !== {1'b1, 1'b0, 1'b1, prev_code}) begin
        bad++;
        $display("FAIL illegal_err r=%0d digit=%0d: got %b want %b", r, a_digit,
                 {a_err, a_frame, a_ready, a_code}, {1'b1, 1'b0, 1'b1, prev_code});
      end
    end
    a_valid = 1'b0;
    step();
    total++;
    if (a_err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_err_clear: got %b want 0", a_err);
    end
    a_digit = 4'd0;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({a_sout, a_frame} !== {(k < 2), 1'b1}) begin
        bad++;
        $display("FAIL illegal_then_zero k=%0d: got %b want %b", k, {a_sout, a_frame}, {(k < 2), 1'b1});
      end
      step();
    end
  endtask

  task automatic test_ignore_busy();
    int d, n;
    logic [4:0] c;
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    d = int'($urandom_range(0, 9));
    c = ref_code(d);
    a_digit = 4'(d);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({a_sout, a_frame, a_done, a_err, a_code} !== {ref_bit(c, k, 1'b1), 1'b1, (k == 4), 1'b0, c}) begin
        bad++;
        $display("FAIL busy_ignore d=%0d k=%0d: got %b want %b", d, k, {a_sout, a_frame, a_done, a_err, a_code},
                 {ref_bit(c, k, 1'b1), 1'b1, (k == 4), 1'b0, c});
      end
      if (k == 1) begin
        a_digit = 4'd3;
        a_valid = 1'b1;
      end else if (k == 2) begin
        a_digit = 4'($urandom_range(10, 15));
      end else begin
        a_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    logic [4:0] c;
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    c = ref_code(9);
    a_digit = 4'd9;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    step();
    step();
    total++;
    if ({a_sout, a_frame} !== {ref_bit(c, 2, 1'b1), 1'b1}) begin
      bad++;
      $display("FAIL midrst_bit2: got %b want %b", {a_sout, a_frame}, {ref_bit(c, 2, 1'b1), 1'b1});
    end
    rst = 1'b1;
    step();
    total++;
    if ({a_sout, a_frame, a_done, a_ready, a_code} !== 9'b0) begin
      bad++;
      $display("FAIL midrst_abort: got %b want 0", {a_sout, a_frame, a_done, a_ready, a_code});
    end
    rst = 1'b0;
    step();
    total++;
    if ({a_ready, a_frame, a_done, a_sout} !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_resume: got %b want 1000", {a_ready, a_frame, a_done, a_sout});
    end
  endtask

  task automatic test_gap0_lsb();
    int d, n, acc, prev;
    logic [4:0] c;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 4 : int'($urandom_range(0, 9));
      c = ref_code(d);
      b_digit = 4'(d);
      b_valid = 1'b1;
      n = 0;
      while (b_ready !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      step();
      acc = cyc;
      if (i > 0) begin
        total++;
        if (acc - prev != 6) begin
          bad++;
          $display("FAIL gap0_period d=%0d: got %0d want 6", d, acc - prev);
        end
      end
      prev = acc;
      for (int k = 0; k < 5; k++) begin
        total++;
        if ({b_sout, b_frame, b_done, b_code} !== {ref_bit(c, k, 1'b0), 1'b1, (k == 4), c}) begin
          bad++;
          $display("FAIL gap0_bit d=%0d k=%0d: got %b want %b", d, k, {b_sout, b_frame, b_done, b_code},
                   {ref_bit(c, k, 1'b0), 1'b1, (k == 4), c});
        end
        step();
      end
      total++;
      if ({b_ready, b_frame, b_sout} !== 3'b100) begin
        bad++;
        $display("FAIL gap0_ready_after_done: got %b want 100", {b_ready, b_frame, b_sout});
      end
      if (i == 4) b_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_ignore_busy();
    test_reset_midframe();
    test_gap0_lsb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
